// File: rtl/datapath_mc.sv
// Simple-RISC datapath: register file, A/B/C registers, shifter, ALU, N/V/Z status,
// plus a multi-cycle shift-add multiplier that owns C/status while it runs.
module datapath_mc #(
   parameter int unsigned DW   = 16,
   parameter int unsigned NREG = 8,
   parameter int unsigned RW   = $clog2(NREG),
   parameter int unsigned PCW  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] readnum,
   input  logic [RW-1:0] writenum,
   input  logic          write,
   input  logic [1:0]    vsel,
   input  logic          loada,
   input  logic          loadb,
   input  logic          loadc,
   input  logic          loads,
   input  logic          asel,
   input  logic          bsel,
   input  logic [1:0]    shift,
   input  logic [1:0]    ALUop,
   input  logic          only_shift,
   input  logic          mul_start,
   input  logic [DW-1:0] sximm5,
   input  logic [DW-1:0] sximm8,
   input  logic [DW-1:0] mdata,
   input  logic [PCW-1:0] PC,
   output logic [DW-1:0] datapath_out,
   output logic          N,
   output logic          V,
   output logic          Z,
   output logic          mul_busy,
   output logic          mul_done
);

   localparam int unsigned CW = $clog2(DW);
   localparam int unsigned PW = 2 * DW;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [DW-1:0] r_regs [NREG];
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [DW-1:0] r_c;
   logic [2:0]    r_status;
   logic [DW-1:0] r_mcand;
   logic [DW-1:0] r_mplier;
   logic [PW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;

   logic [DW-1:0] w_rdata;
   logic [DW-1:0] w_sout;
   logic [DW-1:0] w_ain;
   logic [DW-1:0] w_bin;
   logic [DW-1:0] w_alu;
   logic          w_v;
   logic [DW-1:0] w_out_in;
   logic [DW-1:0] w_data_in;
   logic [PW-1:0] w_pp;
   logic [PW-1:0] w_prod;
   logic          w_start;
   logic          w_last;

   assign w_rdata  = r_regs[readnum];
   assign w_ain    = asel ? '0 : r_a;
   assign w_bin    = bsel ? sximm5 : w_sout;
   assign w_out_in = only_shift ? w_sout : r_c;

   assign datapath_out = w_out_in;
   assign V            = r_status[2];
   assign N            = r_status[1];
   assign Z            = r_status[0];
   assign mul_busy     = r_busy;
   assign mul_done     = r_done;

   // Shifter on B
   always_comb begin
      w_sout = r_b;
      case (shift)
         2'b01:   w_sout = {r_b[DW-2:0], 1'b0};
         2'b10:   w_sout = {1'b0, r_b[DW-1:1]};
         2'b11:   w_sout = {r_b[DW-1], r_b[DW-1:1]};
         default: w_sout = r_b;
      endcase
   end

   // ALU with signed-overflow detection for add/sub
   always_comb begin
      w_alu = '0;
      w_v   = 1'b0;
      case (ALUop)
         2'b00: begin
            w_alu = w_ain + w_bin;
            w_v   = (w_ain[DW-1] == w_bin[DW-1]) && (w_alu[DW-1] != w_ain[DW-1]);
         end
         2'b01: begin
            w_alu = w_ain - w_bin;
            w_v   = (w_ain[DW-1] != w_bin[DW-1]) && (w_alu[DW-1] != w_ain[DW-1]);
         end
         2'b10:   w_alu = w_ain & w_bin;
         default: w_alu = ~w_bin;
      endcase
   end

   // Writeback source select
   always_comb begin
      w_data_in = w_out_in;
      case (vsel)
         2'b01:   w_data_in = sximm8;
         2'b10:   w_data_in = DW'(PC);
         2'b11:   w_data_in = mdata;
         default: w_data_in = w_out_in;
      endcase
   end

   // One multiplier bit per RUN cycle, LSB first
   assign w_pp    = r_mplier[0] ? (PW'(r_mcand) << r_cnt) : '0;
   assign w_prod  = r_acc + w_pp;
   assign w_start = (r_state == S_IDLE) && mul_start;
   assign w_last  = (r_state == S_RUN) && (r_cnt == CW'(DW - 1));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (mul_start) w_state_next = S_RUN;
         S_RUN:   if (r_cnt == CW'(DW - 1)) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next == S_RUN);
         r_done  <= (w_state_next == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_status <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         if (write) r_regs[writenum] <= w_data_in;
         if (loada) r_a <= w_rdata;
         if (loadb) r_b <= w_rdata;

         if (w_start) begin
            r_mcand  <= w_ain;
            r_mplier <= w_bin;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else if (r_state == S_RUN) begin
            r_acc    <= w_prod;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
         end

         // Multiplier owns C/status for the whole RUN phase
         if (w_last) begin
            r_c      <= w_prod[DW-1:0];
            r_status <= {(w_prod[PW-1:DW] != '0), w_prod[DW-1], (w_prod[DW-1:0] == '0)};
         end else if (r_state != S_RUN) begin
            if (loadc) r_c <= w_alu;
            if (loads) r_status <= {w_v, w_alu[DW-1], (w_alu == '0)};
         end
      end
   end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: regfile, ALU/flags, shifter, multiplier handshake.
module tb_datapath_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  readnum, writenum;
   logic        write;
   logic [1:0]  vsel;
   logic        loada, loadb, loadc, loads, asel, bsel;
   logic [1:0]  shift, ALUop;
   logic        only_shift, mul_start;
   logic [15:0] sximm5, sximm8, mdata;
   logic [7:0]  PC;
   logic [15:0] datapath_out;
   logic        N, V, Z, mul_busy, mul_done;

   int errors = 0;
   int checks = 0;

   datapath_mc dut (
      .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum), .write(write),
      .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .only_shift(only_shift),
      .mul_start(mul_start), .sximm5(sximm5), .sximm8(sximm8), .mdata(mdata), .PC(PC),
      .datapath_out(datapath_out), .N(N), .V(V), .Z(Z),
      .mul_busy(mul_busy), .mul_done(mul_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      reset = 0; readnum = 0; writenum = 0; write = 0; vsel = 0;
      loada = 0; loadb = 0; loadc = 0; loads = 0; asel = 0; bsel = 0;
      shift = 0; ALUop = 0; only_shift = 0; mul_start = 0;
      sximm5 = 0; sximm8 = 0; mdata = 0; PC = 0;
   endtask

   task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
      vsel = 2'b01; sximm8 = val; writenum = idx; write = 1;
      tick;
      write = 0; vsel = 2'b00;
   endtask

   task automatic load_ab(input logic [2:0] ia, input logic [2:0] ib);
      readnum = ia; loada = 1; tick; loada = 0;
      readnum = ib; loadb = 1; tick; loadb = 0;
   endtask

   // Reads a register through B and the shifter pass-through
   task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
      readnum = idx; loadb = 1; tick; loadb = 0;
      only_shift = 1; shift = 2'b00; #1;
      val = datapath_out;
      only_shift = 0; #1;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      reset = 1; tick; tick; reset = 0; #1;
      checks++;
      if (datapath_out !== 16'h0 || N !== 0 || V !== 0 || Z !== 0) begin
         errors++;
         $display("FAIL reset_out: got out=%h N=%b V=%b Z=%b, want 0000 0 0 0", datapath_out, N, V, Z);
      end
      checks++;
      if (mul_busy !== 0 || mul_done !== 0) begin
         errors++;
         $display("FAIL reset_mul: got busy=%b done=%b, want 0 0", mul_busy, mul_done);
      end
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), v);
         checks++;
         if (v !== 16'h0) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h, want 0000", i, v);
         end
      end
   endtask

   task automatic test_alu;
      logic [1:0]  ops  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [15:0] exp_c[4] = '{16'h8000, 16'h7FFE, 16'h0001, 16'hFFFE};
      logic [2:0]  exp_f[4] = '{3'b110, 3'b000, 3'b000, 3'b010};   // {V,N,Z}
      write_reg(1, 16'h7FFF);
      write_reg(2, 16'h0001);
      load_ab(1, 2);
      for (int i = 0; i < 4; i++) begin
         ALUop = ops[i]; loadc = 1; loads = 1;
         tick;
         loadc = 0; loads = 0; #1;
         checks++;
         if (datapath_out !== exp_c[i] || {V, N, Z} !== exp_f[i]) begin
            errors++;
            $display("FAIL alu_op%0d: got C=%h VNZ=%b, want C=%h VNZ=%b",
                     i, datapath_out, {V, N, Z}, exp_c[i], exp_f[i]);
         end
      end
      // 0x8000 - 1 overflows to positive
      write_reg(4, 16'h8000);
      load_ab(4, 2);
      ALUop = 2'b01; loadc = 1; loads = 1; tick; loadc = 0; loads = 0; #1;
      checks++;
      if (datapath_out !== 16'h7FFF || {V, N, Z} !== 3'b100) begin
         errors++;
         $display("FAIL alu_sub_ovf: got C=%h VNZ=%b, want C=7fff VNZ=100", datapath_out, {V, N, Z});
      end
      load_ab(2, 2);
      ALUop = 2'b01; loadc = 1; loads = 1; tick; loadc = 0; loads = 0; #1;
      checks++;
      if (datapath_out !== 16'h0000 || {V, N, Z} !== 3'b001) begin
         errors++;
         $display("FAIL alu_zero: got C=%h VNZ=%b, want C=0000 VNZ=001", datapath_out, {V, N, Z});
      end
   endtask

   task automatic test_shift;
      logic [1:0]  ops [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
      logic [15:0] exp [4] = '{16'hC000, 16'h4000, 16'h0002, 16'h8001};
      write_reg(4, 16'h8001);
      readnum = 4; loadb = 1; tick; loadb = 0;
      only_shift = 1;
      for (int i = 0; i < 4; i++) begin
         shift = ops[i]; #1;
         checks++;
         if (datapath_out !== exp[i]) begin
            errors++;
            $display("FAIL shift_op%0d: got %h, want %h", i, datapath_out, exp[i]);
         end
      end
      only_shift = 0; shift = 0; #1;
   endtask

   task automatic test_mul;
      write_reg(5, 16'd3);
      write_reg(6, 16'd5);
      load_ab(5, 6);
      ALUop = 2'b00; loadc = 1; loads = 1; tick; loadc = 0; loads = 0;
      mul_start = 1; tick; mul_start = 0;            // edge t
      for (int c = 1; c <= 16; c++) begin
         if (c == 3) begin
            mul_start = 1; loadc = 1; loads = 1; ALUop = 2'b11;
         end
         #1;
         checks++;
         if (mul_busy !== 1 || mul_done !== 0 || datapath_out !== 16'd8) begin
            errors++;
            $display("FAIL mul_run_c%0d: got busy=%b done=%b C=%h, want 1 0 0008",
                     c, mul_busy, mul_done, datapath_out);
         end
         tick;
         mul_start = 0; loadc = 0; loads = 0; ALUop = 2'b00;
      end
      checks++;
      if (mul_busy !== 0 || mul_done !== 1 || datapath_out !== 16'd15 || {V, N, Z} !== 3'b000) begin
         errors++;
         $display("FAIL mul_result: got busy=%b done=%b C=%h VNZ=%b, want 0 1 000f 000",
                  mul_busy, mul_done, datapath_out, {V, N, Z});
      end
      tick;
      checks++;
      if (mul_done !== 0 || mul_busy !== 0 || datapath_out !== 16'd15) begin
         errors++;
         $display("FAIL mul_done_pulse: got done=%b busy=%b C=%h, want 0 0 000f",
                  mul_done, mul_busy, datapath_out);
      end
   endtask

   task automatic test_mul_zero;
      asel = 1;                                       // Ain = 0
      mul_start = 1; tick; mul_start = 0; asel = 0;
      for (int c = 1; c <= 15; c++) tick;
      checks++;
      if (mul_busy !== 1 || mul_done !== 0) begin
         errors++;
         $display("FAIL mul_zero_len: got busy=%b done=%b before last edge, want 1 0", mul_busy, mul_done);
      end
      tick;
      checks++;
      if (mul_done !== 1 || datapath_out !== 16'h0 || {V, N, Z} !== 3'b001) begin
         errors++;
         $display("FAIL mul_zero: got done=%b C=%h VNZ=%b, want 1 0000 001", mul_done, datapath_out, {V, N, Z});
      end
      tick;
   endtask

   task automatic test_back_to_back;
      int pulses;
      write_reg(1, 16'h0100);
      load_ab(1, 1);
      mul_start = 1; tick; mul_start = 0;
      for (int c = 1; c <= 16; c++) tick;
      checks++;
      if (mul_done !== 1 || datapath_out !== 16'h0 || {V, N, Z} !== 3'b101) begin
         errors++;
         $display("FAIL mul_ovf: got done=%b C=%h VNZ=%b, want 1 0000 101", mul_done, datapath_out, {V, N, Z});
      end
      mul_start = 1;                                  // held through DONE: ignored there
      tick;
      checks++;
      if (mul_busy !== 0 || mul_done !== 0) begin
         errors++;
         $display("FAIL start_in_done: got busy=%b done=%b, want 0 0", mul_busy, mul_done);
      end
      tick;
      mul_start = 0;
      checks++;
      if (mul_busy !== 1) begin
         errors++;
         $display("FAIL back_to_back: got busy=%b, want 1", mul_busy);
      end
      for (int c = 2; c <= 5; c++) tick;
      reset = 1; tick; reset = 0; #1;
      checks++;
      if (mul_busy !== 0 || mul_done !== 0 || datapath_out !== 16'h0 || {V, N, Z} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_run: got busy=%b done=%b C=%h VNZ=%b, want 0 0 0000 000",
                  mul_busy, mul_done, datapath_out, {V, N, Z});
      end
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         tick;
         if (mul_done === 1'b1 || mul_busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d busy/done cycles after reset, want 0", pulses);
      end
   endtask

   task automatic test_regfile;
      logic [15:0] v;
      vsel = 2'b01; sximm8 = 16'hAAAA; writenum = 3; write = 1;
      readnum = 3; loadb = 1;
      tick;
      write = 0; loadb = 0; vsel = 0;
      only_shift = 1; shift = 0; #1;
      checks++;
      if (datapath_out !== 16'h0000) begin
         errors++;
         $display("FAIL rf_no_bypass: got %h, want 0000", datapath_out);
      end
      only_shift = 0;
      read_reg(3, v);
      checks++;
      if (v !== 16'hAAAA) begin
         errors++;
         $display("FAIL rf_next_cycle: got %h, want aaaa", v);
      end
      PC = 8'h5A; vsel = 2'b10; writenum = 7; write = 1; tick; write = 0; vsel = 0;
      read_reg(7, v);
      checks++;
      if (v !== 16'h005A) begin
         errors++;
         $display("FAIL rf_pc: got %h, want 005a", v);
      end
      mdata = 16'h1234; vsel = 2'b11; writenum = 0; write = 1; tick; write = 0; vsel = 0;
      read_reg(0, v);
      checks++;
      if (v !== 16'h1234) begin
         errors++;
         $display("FAIL rf_mdata: got %h, want 1234", v);
      end
      // B holds 0x1234 now; write back B<<1 through out_in
      only_shift = 1; shift = 2'b01; vsel = 2'b00; writenum = 2; write = 1;
      tick;
      write = 0; only_shift = 0; shift = 0;
      read_reg(2, v);
      checks++;
      if (v !== 16'h2468) begin
         errors++;
         $display("FAIL rf_out_in: got %h, want 2468", v);
      end
   endtask

   initial begin
      idle_inputs;
      test_reset;
      test_alu;
      test_shift;
      test_mul;
      test_mul_zero;
      test_back_to_back;
      test_regfile;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
